// File: rtl/decode_pkg.sv
// Shared constants for the instruction decode unit.
//   - 4-bit opcode encodings
//   - ALU select codes
//   - start-channel index per execution FSM
//   - decoder state encoding
package decode_pkg;

    localparam int OPC_W = 4;
    localparam int IDX_W = 3;
    localparam int ALU_W = 3;

    localparam logic [OPC_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'b0010;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'b0011;
    localparam logic [OPC_W-1:0] OP_SUBI  = 4'b0100;
    localparam logic [OPC_W-1:0] OP_NOT   = 4'b0101;
    localparam logic [OPC_W-1:0] OP_AND   = 4'b0111;
    localparam logic [OPC_W-1:0] OP_OR    = 4'b1000;
    localparam logic [OPC_W-1:0] OP_XOR   = 4'b1001;
    localparam logic [OPC_W-1:0] OP_XNOR  = 4'b1010;
    localparam logic [OPC_W-1:0] OP_MOVI  = 4'b1011;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'b1100;
    localparam logic [OPC_W-1:0] OP_STORE = 4'b1101;
    localparam logic [OPC_W-1:0] OP_MOV   = 4'b1111;

    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_NOT  = 3'b010;
    localparam logic [ALU_W-1:0] ALU_AND  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_OR   = 3'b100;
    localparam logic [ALU_W-1:0] ALU_XOR  = 3'b101;
    localparam logic [ALU_W-1:0] ALU_XNOR = 3'b110;

    localparam logic [IDX_W-1:0] IDX_ALU   = 3'd1;
    localparam logic [IDX_W-1:0] IDX_ALUI  = 3'd2;
    localparam logic [IDX_W-1:0] IDX_MOVI  = 3'd3;
    localparam logic [IDX_W-1:0] IDX_LOAD  = 3'd4;
    localparam logic [IDX_W-1:0] IDX_STORE = 3'd5;
    localparam logic [IDX_W-1:0] IDX_MOV   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/opcode_lut.sv
// Combinational opcode lookup.
//   opcode    : in  - opcode field of the instruction
//   start_idx : out - execution channel to start (0 for NOP / undefined)
//   alu_sel   : out - ALU operation, 0 for non-ALU opcodes
//   valid     : out - opcode is defined (NOP included)
//   nop       : out - opcode is NOP
module opcode_lut
    import decode_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0]   opcode,
    output logic [IDX_W-1:0] start_idx,
    output logic [ALU_W-1:0] alu_sel,
    output logic             valid,
    output logic             nop
);

    logic [OPC_W-1:0] op;
    assign op = OPC_W'(opcode);

    always_comb begin
        start_idx = '0;
        alu_sel   = ALU_ADD;
        valid     = 1'b1;
        nop       = 1'b0;
        case (op)
            OP_NOP:   nop = 1'b1;
            OP_ADD:   begin start_idx = IDX_ALU;  alu_sel = ALU_ADD;  end
            OP_ADDI:  begin start_idx = IDX_ALUI; alu_sel = ALU_ADD;  end
            OP_SUB:   begin start_idx = IDX_ALU;  alu_sel = ALU_SUB;  end
            OP_SUBI:  begin start_idx = IDX_ALUI; alu_sel = ALU_SUB;  end
            OP_NOT:   begin start_idx = IDX_ALU;  alu_sel = ALU_NOT;  end
            OP_AND:   begin start_idx = IDX_ALU;  alu_sel = ALU_AND;  end
            OP_OR:    begin start_idx = IDX_ALU;  alu_sel = ALU_OR;   end
            OP_XOR:   begin start_idx = IDX_ALU;  alu_sel = ALU_XOR;  end
            OP_XNOR:  begin start_idx = IDX_ALU;  alu_sel = ALU_XNOR; end
            OP_MOVI:  start_idx = IDX_MOVI;
            OP_LOAD:  start_idx = IDX_LOAD;
            OP_STORE: start_idx = IDX_STORE;
            OP_MOV:   start_idx = IDX_MOV;
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_decode_unit.sv
// Instruction decoder: accepts one instruction at a time, registers its
// operand fields and ALU select, pulses the start line of the target
// execution FSM and waits (bounded by TMO cycles) for its done pulse.
//   clk, rst            : clock, synchronous active-high reset
//   instr_valid/ready   : instruction handshake (ready only while idle)
//   instruction         : {opcode, operand1, operand2}
//   start / fsm_done    : one-hot start pulse / per-channel completion
//   parameter1/2,alu_sel: decoded fields, held until next acceptance
//   busy                : decoder not idle
//   illegal, timeout    : one-cycle error pulses
module instr_decode_unit
    import decode_pkg::*;
#(
    parameter int IW     = 16,
    parameter int OPW    = 4,
    parameter int PW     = 6,
    parameter int NSTART = 7,
    parameter int SELW   = 3,
    parameter int TMO    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [IW-1:0]     instruction,
    output logic              instr_ready,
    output logic [NSTART-1:0] start,
    input  logic [NSTART-1:0] fsm_done,
    output logic [PW-1:0]     parameter1,
    output logic [PW-1:0]     parameter2,
    output logic [SELW-1:0]   alu_sel,
    output logic              busy,
    output logic              illegal,
    output logic              timeout
);

    localparam int CW = $clog2(TMO + 1);

    state_e            state;
    logic [CW-1:0]     wait_cnt;
    logic [NSTART-1:0] tgt_q;

    logic [IDX_W-1:0]  lut_idx;
    logic [ALU_W-1:0]  lut_alu;
    logic              lut_valid;
    logic              lut_nop;

    opcode_lut #(.OPW(OPW)) u_opcode_lut (
        .opcode    (instruction[IW-1 -: OPW]),
        .start_idx (lut_idx),
        .alu_sel   (lut_alu),
        .valid     (lut_valid),
        .nop       (lut_nop)
    );

    logic              accept;
    logic              op_legal;
    logic              is_not;
    logic [NSTART-1:0] tgt_d;

    assign accept   = instr_valid && instr_ready;
    // A defined opcode is still illegal if this build has no such channel.
    assign op_legal = lut_valid && (int'(lut_idx) < NSTART);
    assign is_not   = lut_valid && (lut_alu == ALU_NOT);

    always_comb begin
        tgt_d = '0;
        for (int i = 0; i < NSTART; i++) begin
            tgt_d[i] = (lut_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b0;
            busy        <= 1'b0;
            start       <= '0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            parameter1  <= '0;
            parameter2  <= '0;
            alu_sel     <= '0;
            wait_cnt    <= '0;
            tgt_q       <= '0;
        end else begin
            start   <= '0;
            illegal <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    if (accept) begin
                        parameter1 <= is_not ? instruction[PW-1:0] : instruction[2*PW-1:PW];
                        parameter2 <= instruction[PW-1:0];
                        alu_sel    <= SELW'(lut_alu);
                        if (!op_legal) begin
                            illegal <= 1'b1;
                        end else if (!lut_nop) begin
                            state       <= ST_ISSUE;
                            start       <= tgt_d;
                            tgt_q       <= tgt_d;
                            instr_ready <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                end
                // Done pulses seen here are ignored: the FSM has only just been started.
                ST_ISSUE: begin
                    state    <= ST_WAIT_DONE;
                    wait_cnt <= '0;
                end
                ST_WAIT_DONE: begin
                    if (|(fsm_done & tgt_q)) begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else if (wait_cnt == CW'(TMO - 1)) begin
                        // Final increment lands on TMO, which still fits in CW bits.
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        timeout     <= 1'b1;
                        wait_cnt    <= wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decode_unit.sv
module tb_instr_decode_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instruction;
    logic        instr_ready;
    logic [6:0]  start;
    logic [6:0]  fsm_done;
    logic [5:0]  parameter1;
    logic [5:0]  parameter2;
    logic [2:0]  alu_sel;
    logic        busy;
    logic        illegal;
    logic        timeout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_decode_unit #(.TMO(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_ready (instr_ready),
        .start       (start),
        .fsm_done    (fsm_done),
        .parameter1  (parameter1),
        .parameter2  (parameter2),
        .alu_sel     (alu_sel),
        .busy        (busy),
        .illegal     (illegal),
        .timeout     (timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        n_chk++; if ({instr_ready, busy, start, illegal, timeout} !== 11'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected %b", {instr_ready, busy, start, illegal, timeout}, 11'b0); end
        n_chk++; if ({parameter1, parameter2, alu_sel} !== 15'b0) begin n_fail++; $display("FAIL reset_data: got %h expected %h", {parameter1, parameter2, alu_sel}, 15'b0); end
        rst = 1'b0;
        tick();
        n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", instr_ready); end
    endtask

    task automatic test_add;
        instr_valid = 1'b1;
        instruction = 16'h1042;
        tick();
        instr_valid = 1'b0;
        n_chk++; if (start !== 7'b0000010) begin n_fail++; $display("FAIL add_start: got %b expected %b", start, 7'b0000010); end
        n_chk++; if ({parameter1, parameter2, alu_sel} !== {6'd1, 6'd2, 3'b000}) begin n_fail++; $display("FAIL add_fields: got p1=%0d p2=%0d alu=%b expected p1=1 p2=2 alu=000", parameter1, parameter2, alu_sel); end
        n_chk++; if ({busy, instr_ready} !== 2'b10) begin n_fail++; $display("FAIL add_issue_flags: got busy,ready=%b expected 10", {busy, instr_ready}); end
        tick();
        n_chk++; if ({start, busy} !== 8'b00000001) begin n_fail++; $display("FAIL add_start_one_cycle: got start=%b busy=%b expected start=0000000 busy=1", start, busy); end
        fsm_done = 7'b0000100;
        tick();
        n_chk++; if ({busy, instr_ready} !== 2'b10) begin n_fail++; $display("FAIL add_other_done_ignored: got busy,ready=%b expected 10", {busy, instr_ready}); end
        fsm_done = 7'b0000010;
        tick();
        fsm_done = 7'b0;
        n_chk++; if ({busy, instr_ready, timeout} !== 3'b010) begin n_fail++; $display("FAIL add_done_idle: got busy,ready,timeout=%b expected 010", {busy, instr_ready, timeout}); end
        n_chk++; if ({parameter1, parameter2} !== {6'd1, 6'd2}) begin n_fail++; $display("FAIL add_fields_hold: got p1=%0d p2=%0d expected p1=1 p2=2", parameter1, parameter2); end
    endtask

    task automatic test_illegal;
        instr_valid = 1'b1;
        instruction = 16'h6000;
        tick();
        n_chk++; if ({illegal, start, busy, instr_ready} !== {1'b1, 7'b0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL illegal_pulse: got illegal=%b start=%b busy=%b ready=%b expected 1 0000000 0 1", illegal, start, busy, instr_ready); end
        n_chk++; if ({parameter1, parameter2, alu_sel} !== 15'b0) begin n_fail++; $display("FAIL illegal_fields: got %h expected 0", {parameter1, parameter2, alu_sel}); end
        instruction = 16'h1042;
        tick();
        instr_valid = 1'b0;
        n_chk++; if ({illegal, start} !== {1'b0, 7'b0000010}) begin n_fail++; $display("FAIL illegal_next_accept: got illegal=%b start=%b expected 0 0000010", illegal, start); end
        tick();
        fsm_done = 7'b0000010;
        tick();
        fsm_done = 7'b0;
        n_chk++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_recover_ready: got %b expected 1", instr_ready); end
    endtask

    task automatic test_not;
        instr_valid = 1'b1;
        instruction = 16'h5FC5;
        tick();
        instr_valid = 1'b0;
        n_chk++; if (start !== 7'b0000010) begin n_fail++; $display("FAIL not_start: got %b expected %b", start, 7'b0000010); end
        n_chk++; if ({parameter1, parameter2, alu_sel} !== {6'd5, 6'd5, 3'b010}) begin n_fail++; $display("FAIL not_fields: got p1=%0d p2=%0d alu=%b expected p1=5 p2=5 alu=010", parameter1, parameter2, alu_sel); end
        fsm_done = 7'b0000010;
        tick();
        fsm_done = 7'b0;
        n_chk++; if ({busy, start} !== {1'b1, 7'b0}) begin n_fail++; $display("FAIL not_issue_done_ignored: got busy=%b start=%b expected 1 0000000", busy, start); end
        tick();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL not_wait_busy: got %b expected 1", busy); end
        fsm_done = 7'b0000010;
        tick();
        fsm_done = 7'b0;
        n_chk++; if ({busy, instr_ready} !== 2'b01) begin n_fail++; $display("FAIL not_done_idle: got busy,ready=%b expected 01", {busy, instr_ready}); end
    endtask

    task automatic test_timeout;
        instr_valid = 1'b1;
        instruction = 16'hC083;
        tick();
        instr_valid = 1'b0;
        n_chk++; if (start !== 7'b0010000) begin n_fail++; $display("FAIL load_start: got %b expected %b", start, 7'b0010000); end
        n_chk++; if ({parameter1, parameter2, alu_sel} !== {6'd2, 6'd3, 3'b000}) begin n_fail++; $display("FAIL load_fields: got p1=%0d p2=%0d alu=%b expected p1=2 p2=3 alu=000", parameter1, parameter2, alu_sel); end
        tick();
        fsm_done = 7'b0001000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if ({timeout, busy} !== 2'b01) begin n_fail++; $display("FAIL load_waiting_%0d: got timeout,busy=%b expected 01", i, {timeout, busy}); end
        end
        tick();
        n_chk++; if ({timeout, busy, instr_ready} !== 3'b101) begin n_fail++; $display("FAIL load_timeout: got timeout,busy,ready=%b expected 101", {timeout, busy, instr_ready}); end
        fsm_done = 7'b0;
        tick();
        n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL load_timeout_one_cycle: got %b expected 0", timeout); end
    endtask

    task automatic test_done_on_expiry;
        instr_valid = 1'b1;
        instruction = 16'hC083;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        n_chk++; if ({timeout, busy} !== 2'b01) begin n_fail++; $display("FAIL expiry_pre: got timeout,busy=%b expected 01", {timeout, busy}); end
        fsm_done = 7'b0010000;
        tick();
        fsm_done = 7'b0;
        n_chk++; if ({timeout, busy, instr_ready} !== 3'b001) begin n_fail++; $display("FAIL expiry_done_wins: got timeout,busy,ready=%b expected 001", {timeout, busy, instr_ready}); end
        tick();
        n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL expiry_no_late_timeout: got %b expected 0", timeout); end
    endtask

    task automatic test_reset_mid;
        instr_valid = 1'b1;
        instruction = 16'h1042;
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_chk++; if ({instr_ready, busy, start, illegal, timeout} !== 11'b0) begin n_fail++; $display("FAIL midreset_ctrl: got %b expected %b", {instr_ready, busy, start, illegal, timeout}, 11'b0); end
        n_chk++; if ({parameter1, parameter2, alu_sel} !== 15'b0) begin n_fail++; $display("FAIL midreset_data: got %h expected 0", {parameter1, parameter2, alu_sel}); end
        rst = 1'b0;
        instr_valid = 1'b1;
        instruction = 16'h0000;
        tick();
        n_chk++; if ({instr_ready, start} !== 8'b10000000) begin n_fail++; $display("FAIL midreset_release: got ready=%b start=%b expected 1 0000000", instr_ready, start); end
        tick();
        n_chk++; if ({start, busy, instr_ready} !== 9'b000000001) begin n_fail++; $display("FAIL midreset_nop: got start=%b busy=%b ready=%b expected 0000000 0 1", start, busy, instr_ready); end
        tick();
        instr_valid = 1'b0;
        n_chk++; if ({start, busy} !== 8'b0) begin n_fail++; $display("FAIL midreset_nop_hold: got start=%b busy=%b expected 0000000 0", start, busy); end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instruction = 16'h0000;
        fsm_done    = 7'b0;
        test_reset();
        test_add();
        test_illegal();
        test_not();
        test_timeout();
        test_done_on_expiry();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
